// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register, stall hold buffer and redirect drain
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        flush,
  input  logic [31:0] target_pc,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_id,
  output logic [31:0] inst_id,
  output logic        valid_id,
  output logic        fetch_busy
);

  // ACTIVE: request outstanding; HOLD: word parked while ID stalls;
  // DRAIN: stale response must be swallowed before fetching redirect_pc
  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    HOLD   = 2'd1,
    DRAIN  = 2'd2
  } fetch_state_t;

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  hold_buf, hold_buf_n;
  logic [31:0]  redirect_pc, redirect_pc_n;
  logic [31:0]  pc_id_n, inst_id_n;
  logic         valid_id_n;
  logic         stall;

  assign stall      = ~PCWrite | ~IF_ID_Write;
  assign imem_req   = (state != HOLD);
  assign imem_addr  = pc;
  assign fetch_busy = ((state == ACTIVE) & ~imem_ready) | (state == DRAIN);

  // Next-state and datapath selection; flush always beats stall
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    hold_buf_n    = hold_buf;
    redirect_pc_n = redirect_pc;
    pc_id_n       = pc_id;
    inst_id_n     = inst_id;
    valid_id_n    = valid_id;

    case (state)
      ACTIVE: begin
        if (flush) begin
          pc_id_n    = 32'd0;
          inst_id_n  = NOP_INST;
          valid_id_n = 1'b0;
          if (imem_ready) begin
            pc_n = target_pc;
          end else begin
            redirect_pc_n = target_pc;
            state_n       = DRAIN;
          end
        end else if (imem_ready) begin
          if (!stall) begin
            pc_id_n    = pc;
            inst_id_n  = imem_data;
            valid_id_n = 1'b1;
            pc_n       = pc + 32'd4;
          end else begin
            hold_buf_n = imem_data;
            state_n    = HOLD;
          end
        end else if (IF_ID_Write) begin
          pc_id_n    = 32'd0;
          inst_id_n  = NOP_INST;
          valid_id_n = 1'b0;
        end
      end

      HOLD: begin
        if (flush) begin
          pc_n       = target_pc;
          pc_id_n    = 32'd0;
          inst_id_n  = NOP_INST;
          valid_id_n = 1'b0;
          state_n    = ACTIVE;
        end else if (!stall) begin
          pc_id_n    = pc;
          inst_id_n  = hold_buf;
          valid_id_n = 1'b1;
          pc_n       = pc + 32'd4;
          state_n    = ACTIVE;
        end
      end

      DRAIN: begin
        if (flush || IF_ID_Write) begin
          pc_id_n    = 32'd0;
          inst_id_n  = NOP_INST;
          valid_id_n = 1'b0;
        end
        if (flush) begin
          redirect_pc_n = target_pc;
        end
        if (imem_ready) begin
          pc_n    = flush ? target_pc : redirect_pc;
          state_n = ACTIVE;
        end
      end

      default: begin
        state_n = ACTIVE;
      end
    endcase
  end

  // State and IF/ID register update; reset wins over everything
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ACTIVE;
      pc          <= RESET_PC;
      hold_buf    <= 32'd0;
      redirect_pc <= 32'd0;
      pc_id       <= 32'd0;
      inst_id     <= NOP_INST;
      valid_id    <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      hold_buf    <= hold_buf_n;
      redirect_pc <= redirect_pc_n;
      pc_id       <= pc_id_n;
      inst_id     <= inst_id_n;
      valid_id    <= valid_id_n;
    end
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h00000013, instruction word placed in IF/ID for a bubble.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 PCWrite  input  1  from hazard detection; 0 = hold PC (load-use stall).
REQ-006 IF_ID_Write  input  1  from hazard detection; 0 = hold IF/ID register.
REQ-007 flush  input  1  taken branch/jump resolved in EX; redirect fetch.
REQ-008 target_pc  input  32  redirect address, valid when flush=1.
REQ-009 imem_ready  input  1  instruction memory/I-cache returns data this cycle.
REQ-010 imem_data  input  32  instruction word, valid when imem_ready=1.
REQ-011 imem_req  output  1  fetch request outstanding.
REQ-012 imem_addr  output  32  fetch address, equal to current PC.
REQ-013 pc_id  output  32  IF/ID register: PC of instruction in ID.
REQ-014 inst_id  output  32  IF/ID register: instruction in ID.
REQ-015 valid_id  output  1  IF/ID register: 1 = real instruction, 0 = bubble.
REQ-016 fetch_busy  output  1  fetch waiting on memory (miss or drain).

Function
REQ-017 Internal state: pc (32), hold_buf (32), redirect_pc (32), FSM with states ACTIVE, HOLD, DRAIN.
REQ-018 stall = ~PCWrite | ~IF_ID_Write; flush has priority over stall in every state.
REQ-019 Bubble load = pc_id<=0, inst_id<=NOP_INST, valid_id<=0.
REQ-020 Advance = pc_id<=pc, inst_id<=instruction word, valid_id<=1, pc<=pc+4 (mod 2^32, wrap from 32'hFFFFFFFC to 0).
REQ-021 imem_req=1 in ACTIVE and DRAIN, 0 in HOLD; imem_addr=pc at all times; pc never changes while a request is outstanding without imem_ready.
REQ-022 ACTIVE, flush=1, imem_ready=1: pc<=target_pc, bubble load, stay ACTIVE; returned data dropped.
REQ-023 ACTIVE, flush=1, imem_ready=0: redirect_pc<=target_pc, bubble load, go DRAIN.
REQ-024 ACTIVE, flush=0, imem_ready=1, stall=0: advance with imem_data, stay ACTIVE.
REQ-025 ACTIVE, flush=0, imem_ready=1, stall=1: hold_buf<=imem_data, IF/ID and pc unchanged, go HOLD.
REQ-026 ACTIVE, flush=0, imem_ready=0: pc unchanged; IF_ID_Write=1 -> bubble load; IF_ID_Write=0 -> IF/ID holds.
REQ-027 HOLD, flush=1: pc<=target_pc, bubble load, hold_buf discarded, go ACTIVE.
REQ-028 HOLD, flush=0, stall=1: all state unchanged, stay HOLD.
REQ-029 HOLD, flush=0, stall=0: advance with hold_buf, go ACTIVE.
REQ-030 DRAIN, flush=1: redirect_pc<=target_pc (newest wins), bubble load.
REQ-031 DRAIN, imem_ready=1: data dropped, pc<=redirect_pc (or target_pc if flush=1 same cycle), go ACTIVE.
REQ-032 DRAIN, flush=0: IF_ID_Write=1 -> bubble load, else IF/ID holds.
REQ-033 fetch_busy = (ACTIVE & ~imem_ready) | DRAIN; combinational.
REQ-034 Zero-wait memory (imem_ready=1 every cycle, no stall/flush) sustains one instruction per cycle.

Reset
REQ-035 reset_n=0 at a rising edge: pc<=RESET_PC, FSM<=ACTIVE, pc_id<=0, inst_id<=NOP_INST, valid_id<=0, hold_buf<=0, redirect_pc<=0.
REQ-036 Reset overrides flush, stall and imem_ready, including mid-DRAIN or mid-HOLD; any in-flight response is not captured.
REQ-037 First request after reset is to RESET_PC in the cycle following reset release.

Verification
REQ-038 Reset release, imem_ready=1 always, data=pc-derived -> pc_id 0,4,8 on consecutive cycles, valid_id=1.
REQ-039 imem_ready low 3 cycles at pc=8 -> 3 bubbles, fetch_busy=1 for 3 cycles, imem_addr stays 8, then inst at 8 enters ID.
REQ-040 Load-use: PCWrite=IF_ID_Write=0 one cycle while imem_ready=1 at pc=0x10 -> HOLD, IF/ID unchanged, next cycle inst 0x10 enters ID, no instruction lost or duplicated.
REQ-041 flush=1 target 0x100 with stall=1 same cycle -> bubble in ID, next imem_addr=0x100.
REQ-042 flush target 0x200 during miss, second flush target 0x300 before imem_ready -> stale data dropped, next fetch 0x300.
REQ-043 reset_n=0 during DRAIN -> REQ-035 values next cycle; pc=0xFFFFFFFC advance -> pc=0.
